// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed scan controller for a shared 7-segment decoder
//
// Purpose: snapshots NDIG BCD digits once per frame, then scans them from the most
// to the least significant position. Each digit gets a GUARD all-off interval
// followed by DWELL cycles of drive. Leading-zero blanking and per-digit blink are
// applied on the way to the decoder.
//
// Ports:
//   CLK        system clock
//   nRST       asynchronous active-low reset
//   EN         scan enable, 0 blanks the display and parks in IDLE
//   DIGITS     BCD digits, DIGITS[4k+3:4k] is digit k, k=0 is rightmost
//   BLINK_MASK bit k=1 makes digit k blink
//   LZB        leading-zero blanking enable
//   DEC_DIN    code to the shared decoder, 4'hF is blank
//   nDIG       active-low one-hot digit select
//   FRAME      one-cycle pulse during the LOAD cycle
module seg7_scan_ctrl #(
  parameter int NDIG         = 6,
  parameter int DWELL        = 4096,
  parameter int GUARD        = 64,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                EN,
  input  logic [4*NDIG-1:0]   DIGITS,
  input  logic [NDIG-1:0]     BLINK_MASK,
  input  logic                LZB,
  output logic [3:0]          DEC_DIN,
  output logic [NDIG-1:0]     nDIG,
  output logic                FRAME
);

  localparam int IW   = $clog2(NDIG);
  localparam int CMAX = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW   = $clog2(CMAX);
  localparam int FW   = $clog2(BLINK_FRAMES + 1);

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [FW-1:0] FRAMES_TOP = FW'(BLINK_FRAMES);
  localparam logic [IW-1:0] IDX_TOP    = IW'(NDIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GUARD, S_ON} state_t;

  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt;
  logic [FW-1:0]       r_fcnt;
  logic                r_phase;
  logic [4*NDIG-1:0]   r_sh_digits;
  logic [NDIG-1:0]     r_sh_mask;
  logic                r_sh_lzb;
  logic                r_sh_phase;
  logic [3:0]          r_dec;
  logic [NDIG-1:0]     r_ndig;
  logic                r_frame;

  logic [FW-1:0]       w_fcnt_inc;
  logic                w_fcnt_wrap;
  logic [IW-1:0]       w_idx_dec;
  logic [3:0]          w_first_code;
  logic [3:0]          w_next_code;
  logic [NDIG-1:0]     w_ndig_on;

  // Effective decoder code for digit k: leading-zero blank, then blink, then raw.
  function automatic logic [3:0] eff_code(
    input logic [4*NDIG-1:0] digits,
    input logic [NDIG-1:0]   mask,
    input logic              lzb,
    input logic              phase,
    input logic [IW-1:0]     k
  );
    logic       lead_zero;
    logic       blink_sel;
    logic [3:0] raw;
    lead_zero = 1'b1;
    blink_sel = 1'b0;
    raw       = 4'h0;
    for (int j = 0; j < NDIG; j++) begin
      if (j == int'(k)) begin
        raw       = digits[4*j +: 4];
        blink_sel = mask[j];
      end
      if ((j >= int'(k)) && (digits[4*j +: 4] != 4'h0)) lead_zero = 1'b0;
    end
    if (lzb && (k != '0) && lead_zero) return 4'hF;
    if (phase && blink_sel) return 4'hF;
    return raw;
  endfunction

  assign w_fcnt_inc  = r_fcnt + 1'b1;
  assign w_fcnt_wrap = (w_fcnt_inc == FRAMES_TOP);
  assign w_idx_dec   = r_idx - 1'b1;
  assign w_ndig_on   = ~(NDIG'(1) << r_idx);

  // The first digit's code is needed in the GUARD cycle right after LOAD, before the
  // shadow registers are visible, so it is computed from the values being latched.
  // The blink phase in effect for a frame is the one held before this LOAD's update.
  assign w_first_code = eff_code(DIGITS, BLINK_MASK, LZB, r_phase, IDX_TOP);
  assign w_next_code  = eff_code(r_sh_digits, r_sh_mask, r_sh_lzb, r_sh_phase, w_idx_dec);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_fcnt      <= '0;
      r_phase     <= 1'b0;
      r_sh_digits <= '0;
      r_sh_mask   <= '0;
      r_sh_lzb    <= 1'b0;
      r_sh_phase  <= 1'b0;
      r_dec       <= 4'hF;
      r_ndig      <= '1;
      r_frame     <= 1'b0;
    end else if (!EN) begin
      // Frame counter and blink phase survive a disable so blinking stays regular.
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_dec   <= 4'hF;
      r_ndig  <= '1;
      r_frame <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_LOAD;
          r_frame <= 1'b1;
        end
        S_LOAD: begin
          r_frame     <= 1'b0;
          r_sh_digits <= DIGITS;
          r_sh_mask   <= BLINK_MASK;
          r_sh_lzb    <= LZB;
          r_sh_phase  <= r_phase;
          r_idx       <= IDX_TOP;
          r_cnt       <= '0;
          r_dec       <= w_first_code;
          if (w_fcnt_wrap) begin
            r_fcnt  <= '0;
            r_phase <= ~r_phase;
          end else begin
            r_fcnt <= w_fcnt_inc;
          end
          r_state <= S_GUARD;
        end
        S_GUARD: begin
          if (r_cnt == GUARD_LAST) begin
            r_cnt   <= '0;
            r_ndig  <= w_ndig_on;
            r_state <= S_ON;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ON: begin
          if (r_cnt == DWELL_LAST) begin
            r_cnt  <= '0;
            r_ndig <= '1;
            if (r_idx == '0) begin
              r_dec   <= 4'hF;
              r_frame <= 1'b1;
              r_state <= S_LOAD;
            end else begin
              r_idx   <= w_idx_dec;
              r_dec   <= w_next_code;
              r_state <= S_GUARD;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DEC_DIN = r_dec;
  assign nDIG    = r_ndig;
  assign FRAME   = r_frame;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DWELL = 8;
  localparam int GUARD = 2;
  localparam int BF    = 2;
  localparam int SLOT  = GUARD + DWELL;
  localparam int FL    = 1 + NDIG * SLOT;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        EN = 1'b0;
  logic [15:0] DIGITS = 16'h0;
  logic [3:0]  BLINK_MASK = 4'h0;
  logic        LZB = 1'b0;
  logic [3:0]  DEC_DIN;
  logic [3:0]  nDIG;
  logic        FRAME;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .GUARD(GUARD), .BLINK_FRAMES(BF)) dut (
    .CLK(CLK), .nRST(nRST), .EN(EN), .DIGITS(DIGITS), .BLINK_MASK(BLINK_MASK),
    .LZB(LZB), .DEC_DIN(DEC_DIN), .nDIG(nDIG), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  // Frame-position model: pos=-1 idle, 0 is the LOAD cycle, 1..FL-1 the scan slots.
  int          pos = -1;
  logic [15:0] m_dig;
  logic [3:0]  m_mask;
  logic        m_lzb;
  logic        m_shp;
  int          m_frames = 0;
  logic        m_phase = 1'b0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pos      <= -1;
      m_frames <= 0;
      m_phase  <= 1'b0;
    end else if (!EN) begin
      pos <= -1;
    end else if (pos < 0) begin
      pos <= 0;
    end else begin
      if (pos == 0) begin
        m_dig  <= DIGITS;
        m_mask <= BLINK_MASK;
        m_lzb  <= LZB;
        m_shp  <= m_phase;
        if (m_frames + 1 == BF) begin
          m_frames <= 0;
          m_phase  <= ~m_phase;
        end else begin
          m_frames <= m_frames + 1;
        end
      end
      pos <= (pos + 1) % FL;
    end
  end

  logic [3:0] prev_n = 4'hF;

  always @(negedge CLK) begin
    int         q, slot, r, k;
    logic [3:0] ed, en;
    logic       ef;
    ed = 4'hF; en = 4'hF; ef = 1'b0;
    if (pos == 0) begin
      ef = 1'b1;
    end else if (pos > 0) begin
      q    = pos - 1;
      slot = q / SLOT;
      r    = q % SLOT;
      k    = NDIG - 1 - slot;
      if (m_lzb && k != 0 && (m_dig >> (4 * k)) == 16'h0) ed = 4'hF;
      else if (m_shp && m_mask[k]) ed = 4'hF;
      else ed = 4'((m_dig >> (4 * k)) & 16'hF);
      en = (r < GUARD) ? 4'hF : (~(4'b0001 << k) & 4'hF);
    end
    n_cmp++;
    if (FRAME !== ef || nDIG !== en || (pos != 0 && DEC_DIN !== ed)) begin
      n_bad++;
      $display("FAIL model pos=%0d: got FRAME=%0b nDIG=%b DEC_DIN=%h expected FRAME=%0b nDIG=%b DEC_DIN=%h",
               pos, FRAME, nDIG, DEC_DIN, ef, en, ed);
    end
    n_cmp++;
    if ($countones(~nDIG) > 1 || (prev_n != 4'hF && nDIG != 4'hF && nDIG != prev_n)) begin
      n_bad++;
      $display("FAIL onehot: got nDIG=%b after %b, required at most one low bit and a guard between digits",
               nDIG, prev_n);
    end
    prev_n = nDIG;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_load(input string name);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (FRAME !== 1'b1 && n < 100);
    chk({name, " frame"}, {31'b0, FRAME}, 32'd1);
  endtask

  task automatic check_slot(input int s, input logic [3:0] exp_code, input string name);
    logic [3:0] one;
    one = 4'b1000;
    repeat ((s == 0) ? (1 + GUARD) : SLOT) @(negedge CLK);
    chk({name, " dec"}, {28'b0, DEC_DIN}, {28'b0, exp_code});
    chk({name, " ndig"}, {28'b0, nDIG}, {28'b0, ~(one >> s)});
  endtask

  task automatic check_frame(input logic [15:0] exp, input string name);
    for (int s = 0; s < NDIG; s++)
      check_slot(s, exp[15 - 4*s -: 4], $sformatf("%s d%0d", name, s));
  endtask

  task automatic check_period(input string name);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (FRAME !== 1'b1 && n < 100);
    chk(name, 32'(1 + GUARD + 3 * SLOT + n), 32'd41);
  endtask

  initial begin
    #12;
    chk("reset dec", {28'b0, DEC_DIN}, 32'hF);
    chk("reset ndig", {28'b0, nDIG}, 32'hF);
    chk("reset frame", {31'b0, FRAME}, 32'd0);
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK);
    chk("idle ndig", {28'b0, nDIG}, 32'hF);

    // 1: basic scan, latency and frame period
    EN = 1'b1; DIGITS = 16'h1234;
    @(negedge CLK);
    chk("s1 frame pulse", {31'b0, FRAME}, 32'd1);
    check_frame(16'h1234, "s1a");
    check_period("s1 period");
    check_frame(16'h1234, "s1b");

    // 2: leading-zero blanking
    DIGITS = 16'h0005; LZB = 1'b1;
    wait_load("s2a"); check_frame(16'hFFF5, "s2a");
    DIGITS = 16'h0000;
    wait_load("s2b"); check_frame(16'hFFF0, "s2b");
    DIGITS = 16'h0105;
    wait_load("s2c"); check_frame(16'hF105, "s2c");

    // 3: blink from a fresh frame counter
    nRST = 1'b0;
    @(negedge CLK);
    DIGITS = 16'h1234; LZB = 1'b0; BLINK_MASK = 4'b0011;
    nRST = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      wait_load($sformatf("s3 f%0d", f));
      check_frame((f == 3 || f == 4) ? 16'h12FF : 16'h1234, $sformatf("s3 f%0d", f));
    end

    // 4: input change mid-frame does not tear the frame
    BLINK_MASK = 4'b0000;
    wait_load("s4a");
    check_slot(0, 4'h1, "s4a d0");
    check_slot(1, 4'h2, "s4a d1");
    DIGITS = 16'h9876;
    check_slot(2, 4'h3, "s4a d2");
    check_slot(3, 4'h4, "s4a d3");
    wait_load("s4b"); check_frame(16'h9876, "s4b");

    // 5: EN drop during ON, then restart
    wait_load("s5");
    repeat (1 + GUARD + 2) @(negedge CLK);
    chk("s5 on ndig", {28'b0, nDIG}, 32'h7);
    EN = 1'b0;
    @(negedge CLK);
    chk("s5 off ndig", {28'b0, nDIG}, 32'hF);
    chk("s5 off dec", {28'b0, DEC_DIN}, 32'hF);
    repeat (3) @(negedge CLK);
    EN = 1'b1;
    @(negedge CLK);
    chk("s5 frame pulse", {31'b0, FRAME}, 32'd1);
    check_frame(16'h9876, "s5");

    // 6: asynchronous reset mid-GUARD
    wait_load("s6");
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("s6 async ndig", {28'b0, nDIG}, 32'hF);
    chk("s6 async dec", {28'b0, DEC_DIN}, 32'hF);
    chk("s6 async frame", {31'b0, FRAME}, 32'd0);
    @(negedge CLK);
    DIGITS = 16'h1234;
    nRST = 1'b1;
    @(negedge CLK);
    chk("s6 frame pulse", {31'b0, FRAME}, 32'd1);
    check_frame(16'h1234, "s6");
    check_period("s6 period");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
